// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit:
// funct3 codes, fault codes, IO window offsets, lane helpers.
package lsu_pkg;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } ld_f3_e;

    typedef enum logic [2:0] {
        SB = 3'b000,
        SH = 3'b001,
        SW = 3'b010
    } st_f3_e;

    typedef enum logic [1:0] {
        FLT_OK    = 2'b00,
        FLT_MISAL = 2'b01,
        FLT_UNMAP = 2'b10,
        FLT_ILL   = 2'b11
    } fault_e;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_MEM,
        SEL_LEDR,
        SEL_LEDG,
        SEL_HEX,
        SEL_LCD,
        SEL_SW,
        SEL_BTN
    } sel_e;

    localparam logic [11:0] IO_LEDR = 12'h000;
    localparam logic [11:0] IO_LEDG = 12'h010;
    localparam logic [11:0] IO_HEX  = 12'h020;
    localparam logic [11:0] IO_LCD  = 12'h030;
    localparam logic [11:0] IO_SW   = 12'h800;
    localparam logic [11:0] IO_BTN  = 12'h810;

    typedef struct packed {
        logic       valid;
        fault_e     fault;
        logic       ld;
        logic       mem;
        logic [2:0] f3;
        logic [1:0] lane;
    } rsp_t;

    function automatic logic [3:0] be_from(
        input logic [2:0] f3,
        input logic [1:0] a
    );
        logic [3:0] be;
        case (f3)
            SB:      be = 4'b0001 << a;
            SH:      be = a[1] ? 4'b1100 : 4'b0011;
            SW:      be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] ld_extract(
        input logic [2:0]  f3,
        input logic [1:0]  a,
        input logic [31:0] w
    );
        logic [31:0] s;
        logic [31:0] r;
        s = w >> {a, 3'b000};
        case (f3)
            LB:      r = {{24{s[7]}}, s[7:0]};
            LH:      r = {{16{s[15]}}, s[15:0]};
            LBU:     r = {24'd0, s[7:0]};
            LHU:     r = {16'd0, s[15:0]};
            default: r = s;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/lsu_sync.sv
// Multi-flop synchroniser for asynchronous board inputs.
// Cleared to zero on reset.
module lsu_sync #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] ff [STAGES];

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            for (int s = 0; s < STAGES; s++) ff[s] <= '0;
        end else begin
            ff[0] <= i_d;
            for (int s = 1; s < STAGES; s++) ff[s] <= ff[s-1];
        end
    end

    assign o_q = ff[STAGES-1];

endmodule

// File: rtl/lsu_mmio_pipe.sv
// Load/store unit: byte-lane data RAM plus memory-mapped board IO,
// one-cycle request/response with fault reporting.
module lsu_mmio_pipe
    import lsu_pkg::*;
#(
    parameter logic [31:0] DMEM_BASE   = 32'h0000_2000,
    parameter int          DMEM_WORDS  = 2048,
    parameter logic [31:0] IO_BASE     = 32'h0000_7000,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [31:0] i_addr,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_st_data,
    input  logic [31:0] i_io_sw,
    input  logic [31:0] i_io_btn,
    output logic        o_rsp_valid,
    output logic [31:0] o_ld_data,
    output logic [1:0]  o_fault,
    output logic [31:0] o_io_ledr,
    output logic [31:0] o_io_ledg,
    output logic [31:0] o_io_hex0_7,
    output logic [31:0] o_io_lcd
);

    localparam int          AW         = $clog2(DMEM_WORDS);
    localparam logic [31:0] DMEM_BYTES = 32'(4 * DMEM_WORDS);

    logic [31:0] sw_s;
    logic [31:0] btn_s;

    lsu_sync #(.WIDTH(32), .STAGES(SYNC_STAGES)) u_sync_sw (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   (i_io_sw),
        .o_q   (sw_s)
    );

    lsu_sync #(.WIDTH(32), .STAGES(SYNC_STAGES)) u_sync_btn (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   (i_io_btn),
        .o_q   (btn_s)
    );

    logic [31:0] dm_off;
    logic [31:0] io_off;
    logic [11:0] io_w16;
    logic [11:0] io_w8;
    sel_e        sel;
    logic        ld_ok;
    logic        st_ok;
    logic        misal;
    fault_e      flt;
    logic        go;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] wmask;
    logic [31:0] io_rd;
    logic [AW-1:0] idx;

    logic [31:0] ledr;
    logic [31:0] ledg;
    logic [31:0] hex;
    logic [31:0] lcd;

    always_comb begin
        dm_off = i_addr - DMEM_BASE;
        io_off = i_addr - IO_BASE;
        io_w16 = io_off[11:0] & 12'hFF0;
        io_w8  = io_off[11:0] & 12'hFF8;
        sel    = SEL_NONE;
        if (i_addr >= DMEM_BASE && dm_off < DMEM_BYTES) begin
            sel = SEL_MEM;
        end else if (i_addr >= IO_BASE && io_off < 32'h1000) begin
            unique case (1'b1)
                (io_w16 == IO_LEDR): sel = SEL_LEDR;
                (io_w16 == IO_LEDG): sel = SEL_LEDG;
                (io_w8  == IO_HEX):  sel = SEL_HEX;
                (io_w16 == IO_LCD):  sel = SEL_LCD;
                (io_w16 == IO_SW):   sel = SEL_SW;
                (io_w16 == IO_BTN):  sel = SEL_BTN;
                default:             sel = SEL_NONE;
            endcase
        end
    end

    always_comb begin
        ld_ok = i_funct3 inside {LB, LH, LW, LBU, LHU};
        st_ok = i_funct3 inside {SB, SH, SW};
        misal = (i_funct3[1:0] == 2'b01 && i_addr[0])
             || (i_funct3[1:0] == 2'b10 && i_addr[1:0] != 2'b00);
        // Switches and buttons are read-only; a store there has no target.
        if (i_we ? !st_ok : !ld_ok)
            flt = FLT_ILL;
        else if (misal)
            flt = FLT_MISAL;
        else if (sel == SEL_NONE
              || (i_we && (sel == SEL_SW || sel == SEL_BTN)))
            flt = FLT_UNMAP;
        else
            flt = FLT_OK;
        go = i_req && (flt == FLT_OK);
    end

    always_comb begin
        be    = be_from(i_funct3, i_addr[1:0]);
        wdata = i_st_data << {i_addr[1:0], 3'b000};
        wmask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        idx   = dm_off[AW+1:2];
        case (sel)
            SEL_LEDR: io_rd = ledr;
            SEL_LEDG: io_rd = ledg;
            SEL_HEX:  io_rd = hex;
            SEL_LCD:  io_rd = lcd;
            SEL_SW:   io_rd = sw_s;
            SEL_BTN:  io_rd = btn_s;
            default:  io_rd = '0;
        endcase
    end

    logic [31:0] mem [DMEM_WORDS];
    logic [31:0] ram_q;

    always_ff @(posedge i_clk) begin
        if (go && sel == SEL_MEM) begin
            if (i_we) begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
            end else begin
                ram_q <= mem[idx];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            ledr <= '0;
            ledg <= '0;
            hex  <= '0;
            lcd  <= '0;
        end else if (go && i_we) begin
            case (sel)
                SEL_LEDR: ledr <= (ledr & ~wmask) | (wdata & wmask);
                SEL_LEDG: ledg <= (ledg & ~wmask) | (wdata & wmask);
                SEL_HEX:  hex  <= (hex  & ~wmask) | (wdata & wmask);
                SEL_LCD:  lcd  <= (lcd  & ~wmask) | (wdata & wmask);
                default:  ;
            endcase
        end
    end

    rsp_t        rsp;
    logic [31:0] io_q;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            rsp  <= '0;
            io_q <= '0;
        end else begin
            rsp.valid <= i_req;
            rsp.fault <= i_req ? flt : FLT_OK;
            rsp.ld    <= go && !i_we;
            rsp.mem   <= (sel == SEL_MEM);
            rsp.f3    <= i_funct3;
            rsp.lane  <= i_addr[1:0];
            io_q      <= io_rd;
        end
    end

    assign o_rsp_valid = rsp.valid;
    assign o_fault     = rsp.fault;
    assign o_ld_data   = (rsp.valid && rsp.ld)
                       ? ld_extract(rsp.f3, rsp.lane, rsp.mem ? ram_q : io_q)
                       : 32'd0;
    assign o_io_ledr   = ledr;
    assign o_io_ledg   = ledg;
    assign o_io_hex0_7 = hex;
    assign o_io_lcd    = lcd;

endmodule

// File: tb/tb_lsu_mmio_pipe.sv
// Bench for lsu_mmio_pipe: directed scenarios plus a randomized
// back-to-back stream checked against a byte-level reference model.
module tb_lsu_mmio_pipe;

    localparam int SS = 2;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic        i_req = 1'b0;
    logic        i_we = 1'b0;
    logic [31:0] i_addr = '0;
    logic [2:0]  i_funct3 = '0;
    logic [31:0] i_st_data = '0;
    logic [31:0] i_io_sw = '0;
    logic [31:0] i_io_btn = '0;
    logic        o_rsp_valid;
    logic [31:0] o_ld_data;
    logic [1:0]  o_fault;
    logic [31:0] o_io_ledr;
    logic [31:0] o_io_ledg;
    logic [31:0] o_io_hex0_7;
    logic [31:0] o_io_lcd;

    always #5 i_clk = ~i_clk;

    lsu_mmio_pipe #(
        .DMEM_BASE   (32'h0000_2000),
        .DMEM_WORDS  (2048),
        .IO_BASE     (32'h0000_7000),
        .SYNC_STAGES (SS)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_req       (i_req),
        .i_we        (i_we),
        .i_addr      (i_addr),
        .i_funct3    (i_funct3),
        .i_st_data   (i_st_data),
        .i_io_sw     (i_io_sw),
        .i_io_btn    (i_io_btn),
        .o_rsp_valid (o_rsp_valid),
        .o_ld_data   (o_ld_data),
        .o_fault     (o_fault),
        .o_io_ledr   (o_io_ledr),
        .o_io_ledg   (o_io_ledg),
        .o_io_hex0_7 (o_io_hex0_7),
        .o_io_lcd    (o_io_lcd)
    );

    int n_pass = 0;
    int n_total = 0;
    logic [34:0] got;
    logic [34:0] exp;

    // reference state: DMEM bytes, output regs, synchronised input values
    logic [7:0]  mref [int unsigned];
    logic [31:0] io_ref [4];
    logic [31:0] sw_val;
    logic [31:0] btn_val;

    // called at a negedge; returns at the next negedge
    task automatic txn(input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d);
        i_req = 1'b1;
        i_we = we;
        i_funct3 = f3;
        i_addr = a;
        i_st_data = d;
        @(posedge i_clk);
        #1;
        got = {o_rsp_valid, o_fault, o_ld_data};
        @(negedge i_clk);
        i_req = 1'b0;
    endtask

    function automatic int io_win(input logic [31:0] a);
        logic [31:0] o;
        if (a < 32'h7000) return -1;
        o = a - 32'h7000;
        if (o < 16) return 0;
        if (o < 32) return 1;
        if (o < 40) return 2;
        if (o >= 48 && o < 64) return 3;
        if (o >= 2048 && o < 2064) return 4;
        if (o >= 2064 && o < 2080) return 5;
        return -1;
    endfunction

    function automatic logic is_dm(input logic [31:0] a);
        return a >= 32'h2000 && a < 32'h2000 + 4 * 2048;
    endfunction

    function automatic logic [7:0] rd_byte(input logic [31:0] a);
        int w;
        w = io_win(a);
        if (is_dm(a)) return mref[a];
        if (w == 4) return sw_val[8*a[1:0] +: 8];
        if (w == 5) return btn_val[8*a[1:0] +: 8];
        return io_ref[w][8*a[1:0] +: 8];
    endfunction

    task automatic model_ref(input logic we, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] d,
                             output logic [1:0] ef, output logic [31:0] ed);
        int n;
        int w;
        logic legal;
        logic [31:0] v;
        ed = '0;
        legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        n = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        w = io_win(a);
        if (!legal) ef = 2'd3;
        else if (a % n != 0) ef = 2'd1;
        else if (!is_dm(a) && (w < 0 || (we && w >= 4))) ef = 2'd2;
        else begin
            ef = 2'd0;
            if (we) begin
                for (int i = 0; i < n; i++) begin
                    if (is_dm(a)) mref[a + i] = d[8*i +: 8];
                    else io_ref[w][8*((a + i) % 4) +: 8] = d[8*i +: 8];
                end
            end else begin
                v = '0;
                for (int i = 0; i < n; i++)
                    v = v | (32'(rd_byte(a + i)) << (8 * i));
                if (!f3[2] && n < 4 && v[8*n-1])
                    v = v | (32'hFFFF_FFFF << (8 * n));
                ed = v;
            end
        end
    endtask

    task automatic test_reset();
        i_rst = 1'b0;
        i_req = 1'b1;
        i_funct3 = 3'd2;
        i_addr = 32'h2000;
        repeat (3) @(posedge i_clk);
        #1;
        n_total++;
        if ({o_rsp_valid, o_fault, o_ld_data} !== 35'd0)
            $display("FAIL rst_rsp got %h exp 0", {o_rsp_valid, o_fault, o_ld_data});
        else n_pass++;
        n_total++;
        if ({o_io_ledr, o_io_ledg, o_io_hex0_7, o_io_lcd} !== 128'd0)
            $display("FAIL rst_io got %h exp 0", {o_io_ledr, o_io_ledg, o_io_hex0_7, o_io_lcd});
        else n_pass++;
        @(negedge i_clk);
        i_req = 1'b0;
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;
        n_total++;
        if (o_rsp_valid !== 1'b0) $display("FAIL rst_release valid got %b exp 0", o_rsp_valid);
        else n_pass++;
        @(negedge i_clk);
    endtask

    task automatic test_dmem();
        txn(1, 3'd2, 32'h2000, 32'hDEADBEEF);
        exp = {1'b1, 2'd0, 32'h0};
        n_total++; if (got !== exp) $display("FAIL sw0 got %h exp %h", got, exp); else n_pass++;
        txn(0, 3'd2, 32'h2000, 0);
        exp = {1'b1, 2'd0, 32'hDEADBEEF};
        n_total++; if (got !== exp) $display("FAIL lw0 got %h exp %h", got, exp); else n_pass++;
        txn(1, 3'd0, 32'h2003, 32'h80);
        txn(0, 3'd2, 32'h2000, 0);
        exp = {1'b1, 2'd0, 32'h80ADBEEF};
        n_total++; if (got !== exp) $display("FAIL lw_after_sb got %h exp %h", got, exp); else n_pass++;
        txn(0, 3'd0, 32'h2003, 0);
        exp = {1'b1, 2'd0, 32'hFFFFFF80};
        n_total++; if (got !== exp) $display("FAIL lb got %h exp %h", got, exp); else n_pass++;
        txn(0, 3'd4, 32'h2003, 0);
        exp = {1'b1, 2'd0, 32'h00000080};
        n_total++; if (got !== exp) $display("FAIL lbu got %h exp %h", got, exp); else n_pass++;
        txn(1, 3'd1, 32'h2002, 32'h8001);
        txn(0, 3'd1, 32'h2002, 0);
        exp = {1'b1, 2'd0, 32'hFFFF8001};
        n_total++; if (got !== exp) $display("FAIL lh got %h exp %h", got, exp); else n_pass++;
        txn(0, 3'd5, 32'h2002, 0);
        exp = {1'b1, 2'd0, 32'h00008001};
        n_total++; if (got !== exp) $display("FAIL lhu got %h exp %h", got, exp); else n_pass++;
        txn(0, 3'd1, 32'h2001, 0);
        exp = {1'b1, 2'd1, 32'h0};
        n_total++; if (got !== exp) $display("FAIL lh_misal got %h exp %h", got, exp); else n_pass++;
        txn(1, 3'd2, 32'h2001, 32'h11111111);
        exp = {1'b1, 2'd1, 32'h0};
        n_total++; if (got !== exp) $display("FAIL sw_misal got %h exp %h", got, exp); else n_pass++;
        txn(0, 3'd2, 32'h2000, 0);
        exp = {1'b1, 2'd0, 32'h8001BEEF};
        n_total++; if (got !== exp) $display("FAIL fault_no_write got %h exp %h", got, exp); else n_pass++;
        txn(1, 3'd2, 32'h3FFC, 32'hCAFEF00D);
        txn(0, 3'd2, 32'h3FFC, 0);
        exp = {1'b1, 2'd0, 32'hCAFEF00D};
        n_total++; if (got !== exp) $display("FAIL last_word got %h exp %h", got, exp); else n_pass++;
        txn(0, 3'd2, 32'h4000, 0);
        exp = {1'b1, 2'd2, 32'h0};
        n_total++; if (got !== exp) $display("FAIL past_end got %h exp %h", got, exp); else n_pass++;
        txn(0, 3'd2, 32'h1FFC, 0);
        exp = {1'b1, 2'd2, 32'h0};
        n_total++; if (got !== exp) $display("FAIL below_base got %h exp %h", got, exp); else n_pass++;
        txn(0, 3'd2, 32'h1FFE, 0);
        exp = {1'b1, 2'd1, 32'h0};
        n_total++; if (got !== exp) $display("FAIL misal_over_unmap got %h exp %h", got, exp); else n_pass++;
    endtask

    task automatic test_io();
        txn(1, 3'd2, 32'h7000, 32'h1234);
        n_total++; if (o_io_ledr !== 32'h1234) $display("FAIL ledr got %h exp 00001234", o_io_ledr); else n_pass++;
        txn(0, 3'd2, 32'h700C, 0);
        exp = {1'b1, 2'd0, 32'h1234};
        n_total++; if (got !== exp) $display("FAIL ledr_alias got %h exp %h", got, exp); else n_pass++;
        txn(1, 3'd2, 32'h7800, 32'hFFFF);
        exp = {1'b1, 2'd2, 32'h0};
        n_total++; if (got !== exp) $display("FAIL sw_store got %h exp %h", got, exp); else n_pass++;
        n_total++; if (o_io_ledr !== 32'h1234) $display("FAIL ledr_kept got %h exp 00001234", o_io_ledr); else n_pass++;
        txn(1, 3'd0, 32'h7011, 32'hAB);
        n_total++; if (o_io_ledg !== 32'h0000AB00) $display("FAIL ledg_sb got %h exp 0000ab00", o_io_ledg); else n_pass++;
        txn(0, 3'd0, 32'h7011, 0);
        exp = {1'b1, 2'd0, 32'hFFFFFFAB};
        n_total++; if (got !== exp) $display("FAIL ledg_lb got %h exp %h", got, exp); else n_pass++;
        txn(1, 3'd1, 32'h7026, 32'hBEEF);
        n_total++; if (o_io_hex0_7 !== 32'hBEEF0000) $display("FAIL hex_sh got %h exp beef0000", o_io_hex0_7); else n_pass++;
        txn(0, 3'd2, 32'h7028, 0);
        exp = {1'b1, 2'd2, 32'h0};
        n_total++; if (got !== exp) $display("FAIL hex_gap got %h exp %h", got, exp); else n_pass++;
        txn(0, 3'd3, 32'h2000, 0);
        exp = {1'b1, 2'd3, 32'h0};
        n_total++; if (got !== exp) $display("FAIL illegal_ld got %h exp %h", got, exp); else n_pass++;
        txn(1, 3'd4, 32'h2001, 32'h5);
        exp = {1'b1, 2'd3, 32'h0};
        n_total++; if (got !== exp) $display("FAIL illegal_st got %h exp %h", got, exp); else n_pass++;
    endtask

    task automatic test_sync();
        i_io_sw = 32'hA5;
        for (int k = 0; k <= SS; k++) begin
            txn(0, 3'd2, 32'h7800, 0);
            exp = {1'b1, 2'd0, (k < SS) ? 32'h0 : 32'hA5};
            n_total++; if (got !== exp) $display("FAIL sync_lat%0d got %h exp %h", k, got, exp); else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        for (int k = 0; k < 8; k++) begin
            d = $urandom;
            txn(1, 3'd2, 32'h2010 + 32'(4 * k), d);
            txn(0, 3'd2, 32'h2010 + 32'(4 * k), 0);
            exp = {1'b1, 2'd0, d};
            n_total++; if (got !== exp) $display("FAIL b2b%0d got %h exp %h", k, got, exp); else n_pass++;
        end
        @(posedge i_clk);
        #1;
        n_total++; if (o_rsp_valid !== 1'b0) $display("FAIL idle_valid got %b exp 0", o_rsp_valid); else n_pass++;
        @(negedge i_clk);
    endtask

    task automatic test_reset_mid();
        txn(1, 3'd2, 32'h7030, 32'h55);
        n_total++; if (o_io_lcd !== 32'h55) $display("FAIL lcd_set got %h exp 00000055", o_io_lcd); else n_pass++;
        i_req = 1'b1;
        i_we = 1'b0;
        i_funct3 = 3'd2;
        i_addr = 32'h7030;
        @(posedge i_clk);
        #2;
        i_rst = 1'b0;
        #1;
        n_total++;
        if ({o_rsp_valid, o_fault, o_ld_data} !== 35'd0)
            $display("FAIL mid_rst_rsp got %h exp 0", {o_rsp_valid, o_fault, o_ld_data});
        else n_pass++;
        n_total++;
        if ({o_io_ledr, o_io_ledg, o_io_hex0_7, o_io_lcd} !== 128'd0)
            $display("FAIL mid_rst_io got %h exp 0", {o_io_ledr, o_io_ledg, o_io_hex0_7, o_io_lcd});
        else n_pass++;
        @(negedge i_clk);
        i_req = 1'b0;
        @(negedge i_clk);
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;
        n_total++; if (o_rsp_valid !== 1'b0) $display("FAIL post_rst_valid got %b exp 0", o_rsp_valid); else n_pass++;
        @(negedge i_clk);
        txn(0, 3'd2, 32'h7800, 0);
        exp = {1'b1, 2'd0, 32'h0};
        n_total++; if (got !== exp) $display("FAIL sync_cleared got %h exp %h", got, exp); else n_pass++;
        txn(0, 3'd2, 32'h7800, 0);
        exp = {1'b1, 2'd0, 32'hA5};
        n_total++; if (got !== exp) $display("FAIL sync_refill got %h exp %h", got, exp); else n_pass++;
    endtask

    task automatic test_random();
        int offs[6] = '{0, 16, 32, 48, 2048, 2064};
        int span[6] = '{16, 16, 8, 16, 16, 16};
        logic [31:0] bad[6] = '{32'h1FFC, 32'h4000, 32'h7028, 32'h7040, 32'h0, 32'h7FFC};
        logic [2:0] lds[5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        logic [31:0] a;
        logic [31:0] d;
        logic [2:0] f3;
        logic we;
        logic [1:0] ef;
        logic [31:0] ed;
        int k;
        int w;
        sw_val = $urandom;
        btn_val = $urandom;
        i_io_sw = sw_val;
        i_io_btn = btn_val;
        repeat (SS + 2) @(negedge i_clk);
        for (int i = 0; i < 16; i++) begin
            d = $urandom;
            model_ref(1, 3'd2, 32'h2100 + 32'(4 * i), d, ef, ed);
            txn(1, 3'd2, 32'h2100 + 32'(4 * i), d);
        end
        for (int i = 0; i < 4; i++) begin
            d = $urandom;
            model_ref(1, 3'd2, 32'h7000 + 32'(offs[i]), d, ef, ed);
            txn(1, 3'd2, 32'h7000 + 32'(offs[i]), d);
        end
        for (int i = 0; i < 400; i++) begin
            k = $urandom_range(0, 99);
            if (k < 55) begin
                a = 32'h2100 + $urandom_range(0, 63);
            end else if (k < 90) begin
                w = $urandom_range(0, 5);
                a = 32'h7000 + 32'(offs[w]) + $urandom_range(0, span[w] - 1);
            end else begin
                a = bad[$urandom_range(0, 5)];
            end
            we = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) f3 = 3'($urandom);
            else if (we) f3 = 3'($urandom_range(0, 2));
            else f3 = lds[$urandom_range(0, 4)];
            d = $urandom;
            model_ref(we, f3, a, d, ef, ed);
            txn(we, f3, a, d);
            exp = {1'b1, ef, ed};
            n_total++;
            if (got !== exp)
                $display("FAIL rnd%0d we=%b f3=%0d a=%h got %h exp %h", i, we, f3, a, got, exp);
            else n_pass++;
            n_total++;
            if ({o_io_ledr, o_io_ledg, o_io_hex0_7, o_io_lcd} !== {io_ref[0], io_ref[1], io_ref[2], io_ref[3]})
                $display("FAIL rnd_io%0d got %h exp %h", i,
                         {o_io_ledr, o_io_ledg, o_io_hex0_7, o_io_lcd},
                         {io_ref[0], io_ref[1], io_ref[2], io_ref[3]});
            else n_pass++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_dmem();
        test_io();
        test_sync();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
